// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_sequencer_if : control/status bundle between core and PC sequencer |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface pc_sequencer_if #(
   parameter int PC_W  = 9,
   parameter int CNT_W = 16
);
   logic              stall_i;
   logic              pc_sel_i;
   logic [31:0]       br_pc_i;
   logic              halt_i;
   logic              resume_i;
   logic [PC_W-1:0]   pc_o;
   logic              pc_valid_o;
   logic              flush_o;
   logic              halted_o;
   logic [CNT_W-1:0]  redirect_cnt_o;

   modport master (
      output stall_i, pc_sel_i, br_pc_i, halt_i, resume_i,
      input  pc_o, pc_valid_o, flush_o, halted_o, redirect_cnt_o
   );

   modport slave (
      input  stall_i, pc_sel_i, br_pc_i, halt_i, resume_i,
      output pc_o, pc_valid_o, flush_o, halted_o, redirect_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pc_sequencer : fetch PC controller with redirect flush window, HALT   |
// | parking and a saturating taken-redirect counter. Revision: 1.0        |
// +-----------------------------------------------------------------------+
module pc_sequencer #(
   parameter int PC_W      = 9,
   parameter int FLUSH_CYC = 2,
   parameter int CNT_W     = 16
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);
   localparam int FC_W = $clog2(FLUSH_CYC + 1);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [PC_W-1:0]   pc, pc_nxt, pc_inc, br_pc;
   logic              pc_valid, pc_valid_nxt;
   logic              flush, flush_nxt;
   logic              halted, halted_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [FC_W-1:0]   fcnt, fcnt_nxt;

   // Upper target bits fall outside instruction memory and are dropped.
   logic unused_br_hi;
   assign unused_br_hi = ^bus.br_pc_i[31:PC_W];

   assign pc_inc = pc + PC_W'(4);
   assign br_pc  = bus.br_pc_i[PC_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= RUN;
         pc       <= '0;
         pc_valid <= 1'b1;
         flush    <= 1'b0;
         halted   <= 1'b0;
         cnt      <= '0;
         fcnt     <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         pc_valid <= pc_valid_nxt;
         flush    <= flush_nxt;
         halted   <= halted_nxt;
         cnt      <= cnt_nxt;
         fcnt     <= fcnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      pc_valid_nxt = pc_valid;
      flush_nxt    = flush;
      halted_nxt   = halted;
      cnt_nxt      = cnt;
      fcnt_nxt     = fcnt;
      case (state)
         RUN: begin
            if (bus.halt_i) begin
               pc_nxt       = br_pc;
               state_nxt    = HALT;
               halted_nxt   = 1'b1;
               pc_valid_nxt = 1'b0;
               flush_nxt    = 1'b1;
            end else if (bus.pc_sel_i) begin
               pc_nxt    = br_pc;
               cnt_nxt   = (&cnt) ? cnt : cnt + CNT_W'(1);
               fcnt_nxt  = FC_W'(FLUSH_CYC);
               flush_nxt = 1'b1;
               state_nxt = FLUSH;
            end else if (!bus.stall_i) begin
               pc_nxt = pc_inc;
            end
         end
         FLUSH: begin
            // Redirect/halt here come from squashed wrong-path instructions.
            if (!bus.stall_i) begin
               pc_nxt = pc_inc;
            end
            if (fcnt <= FC_W'(1)) begin
               fcnt_nxt  = '0;
               flush_nxt = 1'b0;
               state_nxt = RUN;
            end else begin
               fcnt_nxt = fcnt - FC_W'(1);
            end
         end
         HALT: begin
            if (bus.resume_i) begin
               pc_nxt       = pc_inc;
               state_nxt    = RUN;
               halted_nxt   = 1'b0;
               pc_valid_nxt = 1'b1;
               flush_nxt    = 1'b0;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   assign bus.pc_o           = pc;
   assign bus.pc_valid_o     = pc_valid;
   assign bus.flush_o        = flush;
   assign bus.halted_o       = halted;
   assign bus.redirect_cnt_o = cnt;
endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch-side PC controller for the 5-stage RISC-V core. Owns the PC register and sequences it from the branch unit's redirect outputs (select, target), the hazard unit's stall and the halt decode. Generates a registered pipeline squash window after each redirect, parks the core in a HALT state until resumed, and counts taken redirects for debug.

Parameters:
PC_W, 9, PC register width (byte address; instruction memory depth 2^PC_W bytes)
FLUSH_CYC, 2, cycles flush_o is held after an accepted redirect (≥1)
CNT_W, 16, width of redirect counter

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
stall_i  in  1  hazard-unit stall: hold PC
pc_sel_i  in  1  branch unit redirect request (branch taken / jal / jalr / halt)
br_pc_i  in  32  redirect target from branch unit
halt_i  in  1  halt instruction resolved in EX
resume_i  in  1  debug/host resume from HALT
pc_o  out  PC_W  current fetch PC
pc_valid_o  out  1  fetch at pc_o is valid
flush_o  out  1  squash IF/ID and ID/EX contents
halted_o  out  1  core parked in HALT
redirect_cnt_o  out  CNT_W  number of accepted non-halt redirects

Behaviour:
- Reset (async, immediate, also mid-operation): state=RUN, pc_o=0, pc_valid_o=1, flush_o=0, halted_o=0, redirect_cnt_o=0, flush counter=0.
- All outputs registered; every decision samples inputs at the rising edge and takes effect after that edge.
- States: RUN, FLUSH, HALT.
- RUN, priority halt > redirect > stall > increment:
  - halt_i=1 (pc_sel_i may also be 1): pc_o <= br_pc_i[PC_W-1:0]; -> HALT; halted_o<=1, pc_valid_o<=0, flush_o<=1. Counter not incremented.
  - pc_sel_i=1, halt_i=0: pc_o <= br_pc_i[PC_W-1:0]; redirect_cnt_o += 1; flush counter <= FLUSH_CYC; flush_o<=1; -> FLUSH. Redirect overrides stall_i.
  - stall_i=1 only: pc_o holds.
  - otherwise: pc_o <= pc_o + 4.
- FLUSH:
  - flush_o=1 for exactly FLUSH_CYC cycles after the redirect edge; counter decrements each cycle; at 1 -> RUN with flush_o<=0.
  - pc_sel_i and halt_i ignored (they originate from squashed wrong-path instructions).
  - stall_i honoured for PC (hold), but the flush counter still decrements.
  - no stall: pc_o <= pc_o + 4.
- HALT:
  - pc_o holds; flush_o=1; pc_valid_o=0; halted_o=1.
  - stall_i, pc_sel_i and halt_i ignored.
  - resume_i=1: pc_o <= pc_o + 4; -> RUN; halted_o<=0, pc_valid_o<=1, flush_o<=0.
  - resume_i outside HALT is ignored.
- Arithmetic: pc_o + 4 wraps modulo 2^PC_W (e.g. PC_W=9: 0x1FC -> 0x000). br_pc_i[31:PC_W] is discarded. br_pc_i bits [1:0] pass through unchanged (no alignment fault).
- redirect_cnt_o saturates at all-ones (no wrap).

Test Plan:
- Reset then 4 free-running cycles -> pc_o 0x000,0x004,0x008,0x00C,0x010; flush_o=0; pc_valid_o=1.
- At pc_o=0x010, pc_sel_i=1, br_pc_i=0x40 -> pc_o=0x040 next cycle; flush_o=1 for exactly 2 cycles while pc_o steps 0x044, 0x048; redirect_cnt_o=1. A pc_sel_i=1 with br_pc_i=0x80 on the first flush cycle is ignored.
- stall_i=1 for 3 cycles at pc_o=0x020 -> pc_o stays 0x020. pc_sel_i=1 with stall_i=1 and br_pc_i=0x100 -> pc_o=0x100 and flush starts.
- halt_i=1 and pc_sel_i=1 with br_pc_i=0x030 -> pc_o=0x030, halted_o=1, pc_valid_o=0, flush_o=1, counter unchanged. Held 10 cycles with stall/pc_sel toggling -> no change. resume_i=1 -> pc_o=0x034, halted_o=0, flush_o=0.
- PC_W=9 at pc_o=0x1FC, no stall -> pc_o=0x000. br_pc_i=0xFFFF_F204 -> pc_o=0x004.
- Assert reset asynchronously mid-FLUSH and mid-HALT -> outputs return to reset values before the next clk edge. CNT_W=2 with 5 redirects -> redirect_cnt_o sticks at 3.
